fifo_sync: RTL and testbench

FIFO_SYNC -- requirements
Module: fifo_sync

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_mem.sv | 50 +++++
 rtl/fifo_sync.sv | 74 +++++++
 tb/tb_fifo_sync.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and pointer sizing for the synchronous FIFO.
// No logic; constants and a width helper only.
package fifo_pkg;

    localparam int FIFO_DEPTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 32;

    // One extra MSB wrap bit distinguishes full from empty when addresses match
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one registered read port.
// Latency: read data valid after the accepting edge; no backpressure, caller gates ports.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DEPTH      = FIFO_DEPTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_vld,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  rd_vld,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_dat_q;
    logic [DATA_WIDTH-1:0] rd_dat_d;

    // Read and write never target the same live entry: reads are blocked
    // when empty and writes when full, so no bypass path is needed.
    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_vld) begin
            rd_dat_d = mem_q[rd_addr];
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with wrap-bit pointers; full/empty decoded from registered pointers.
// Latency: one clock read; backpressure: writes dropped when full, reads ignored when empty.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);

    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic          wr_acc;
    logic          rd_acc;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

    // Gating on the flags yields read-only when full and write-only when empty
    assign wr_acc = cs && wr_en && !full;
    assign rd_acc = cs && rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_mem #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_vld  (wr_acc),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_dat  (data_in),
        .rd_vld  (rd_acc),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_dat  (data_out)
    );

endmodule

// File: tb/tb_fifo_sync.sv
// Directed checks of fifo_sync at default size (8 x 32).
module tb_fifo_sync;

    logic        clk;
    logic        rst_n;
    logic        cs;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        empty;
    logic        full;

    int checks;
    int errors;

    fifo_sync #(.FIFO_DEPTH(8), .DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Each op drives one edge and returns 1 time unit after it
    task automatic cycle(input logic c, input logic w, input logic r, input logic [31:0] d);
        cs      = c;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
        cs    = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] d);
        cycle(1'b1, 1'b1, 1'b0, d);
    endtask

    task automatic do_read();
        cycle(1'b1, 1'b0, 1'b1, 32'd0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        cs      = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;

        // Reset without any clock edge
        #2;
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_dout", data_out, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ordering
        do_write(32'd1);
        check_val("w1_empty", 32'(empty), 32'd0);
        do_write(32'd10);
        do_write(32'd100);
        do_read();
        check_val("r_1", data_out, 32'd1);
        do_read();
        check_val("r_10", data_out, 32'd10);
        do_read();
        check_val("r_100", data_out, 32'd100);
        check_val("ord_empty", 32'(empty), 32'd1);

        // Single-entry round trips across pointer wrap
        for (int i = 0; i < 8; i++) begin
            do_write(32'd1 << i);
            do_read();
            check_val("pow_dout", data_out, 32'd1 << i);
            check_val("pow_empty", 32'(empty), 32'd1);
        end

        // Fill, overflow drop, drain
        for (int i = 0; i < 8; i++) begin
            do_write(32'd1 << i);
            if (i == 6) check_val("fill7_full", 32'(full), 32'd0);
        end
        check_val("fill8_full", 32'(full), 32'd1);
        do_write(32'd999);
        check_val("ovf_full", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            do_read();
            check_val("drain_dout", data_out, 32'd1 << i);
            if (i == 0) check_val("drain1_full", 32'(full), 32'd0);
        end
        check_val("drain_empty", 32'(empty), 32'd1);

        // Read on empty and cs=0 activity are no-ops
        do_read();
        check_val("rdempty_dout", data_out, 32'd128);
        check_val("rdempty_empty", 32'(empty), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 32'd55);
        check_val("cs0_wr_empty", 32'(empty), 32'd1);
        do_write(32'd7);
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        check_val("cs0_rd_dout", data_out, 32'd128);
        check_val("cs0_rd_empty", 32'(empty), 32'd0);
        do_read();
        check_val("cs0_after", data_out, 32'd7);

        // Simultaneous read/write mid-occupancy
        do_write(32'd20);
        do_write(32'd21);
        cycle(1'b1, 1'b1, 1'b1, 32'd22);
        check_val("rw_mid_dout", data_out, 32'd20);
        do_read();
        check_val("rw_mid_r21", data_out, 32'd21);
        do_read();
        check_val("rw_mid_r22", data_out, 32'd22);
        check_val("rw_mid_empty", 32'(empty), 32'd1);

        // Simultaneous while full: only the read happens
        for (int i = 0; i < 8; i++) do_write(32'd30 + 32'(i));
        cycle(1'b1, 1'b1, 1'b1, 32'd99);
        check_val("rw_full_dout", data_out, 32'd30);
        check_val("rw_full_full", 32'(full), 32'd0);
        for (int i = 1; i < 8; i++) begin
            do_read();
            check_val("rw_full_drain", data_out, 32'd30 + 32'(i));
        end
        check_val("rw_full_empty", 32'(empty), 32'd1);

        // Simultaneous while empty: only the write happens
        cycle(1'b1, 1'b1, 1'b1, 32'd77);
        check_val("rw_empty_dout", data_out, 32'd37);
        check_val("rw_empty_empty", 32'(empty), 32'd0);
        do_read();
        check_val("rw_empty_r77", data_out, 32'd77);

        // Asynchronous reset mid-operation
        do_write(32'd3);
        do_write(32'd4);
        do_write(32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_empty", 32'(empty), 32'd1);
        check_val("arst_full", 32'(full), 32'd0);
        check_val("arst_dout", data_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_write(32'd5);
        check_val("post_rst_empty", 32'(empty), 32'd0);
        do_read();
        check_val("post_rst_r5", data_out, 32'd5);
        check_val("post_rst_end", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
